conv_window_sequencer: RTL
==========================

Name: conv_window_sequencer

Overview:
Controller that sequences the floating-point multiply-and-accumulate datapath for one 2-D valid-mode convolution.
- From latched filter/data dimensions and RAM base addresses, it walks every output pixel and every filter tap in order.
- Each beat issues a paired data-RAM element address and filter-RAM element address.
- lastOut marks the final tap of each output pixel so the MAC emits one sum per pixel.
- Sits between the RISC-V configuration registers and the RAM read ports / MAC input stage; downstream FIFO backpressure arrives via readyIn.

Parameters:
ADDR_WIDTH  12  element address width (4096-element RAM)
DIM_WIDTH   7   width of each dimension field (max 64)

Ports:
clkIn        input   1           clock
rstIn        input   1           asynchronous active-high reset
startIn      input   1           pulse: latch config, begin job (ignored while busy)
filtRowsIn   input   DIM_WIDTH   filter rows
filtColsIn   input   DIM_WIDTH   filter cols
dataRowsIn   input   DIM_WIDTH   data rows
dataColsIn   input   DIM_WIDTH   data cols
dataBaseIn   input   ADDR_WIDTH  element address of data[0][0]
filtBaseIn   input   ADDR_WIDTH  element address of filt[0][0]
busyOut      output  1           job in progress
doneOut      output  1           one-cycle pulse, job complete
errOut       output  1           one-cycle pulse, config rejected
dataAddrOut  output  ADDR_WIDTH  data element read address
filtAddrOut  output  ADDR_WIDTH  filter element read address
validOut     output  1           address pair valid
lastOut      output  1           final tap of current output pixel
readyIn      input   1           downstream accepts beat

Behaviour:
- Reset (async, any state): state=IDLE; every output 0; all counters 0. Reset mid-job abandons the job silently: no doneOut, no errOut.
- States:
  - IDLE: on startIn, latch all config inputs -> CHECK.
  - CHECK (1 cycle):
    - Any dimension 0, filtRows>dataRows, or filtCols>dataCols -> errOut=1 for one cycle -> IDLE.
    - Otherwise initialise counters -> RUN.
  - RUN: issue beats (see below) -> DONE after the final handshake.
  - DONE (1 cycle): doneOut=1 -> IDLE.
- busyOut=1 in CHECK, RUN and DONE.
- Output dimensions: outRows=dataRows-filtRows+1, outCols=dataCols-filtCols+1.
- Loop order, outermost to innermost: outRow, outCol, fRow, fCol.
- Addresses:
  - dataAddr = dataBase + (outRow+fRow)*dataCols + outCol + fCol
  - filtAddr = filtBase + fRow*filtCols + fCol
  - Both mod 2^ADDR_WIDTH; wrap is silent, with no range check.
  - Generated incrementally: window-base and row-pointer registers advanced by +1 / +dataCols / +filtCols. No multiplier in RUN.
- Outputs are registered. validOut rises the cycle after CHECK, so the first beat appears 2 cycles after the startIn cycle.
- Handshake: a beat transfers when validOut&&readyIn.
  - While validOut&&!readyIn, validOut, dataAddrOut, filtAddrOut and lastOut hold stable.
  - validOut never drops without a transfer.
- Issue rate: with readyIn held high, one beat per cycle, no bubbles, including across pixel boundaries.
- lastOut=1 exactly on beats with fRow=filtRows-1 and fCol=filtCols-1.
- Total beats = outRows*outCols*filtRows*filtCols.
- Final beat: the cycle after its handshake, validOut=0 and state=DONE; doneOut pulses in that cycle.
- startIn while busy: ignored; config changes on inputs while busy have no effect.
- startIn in the DONE cycle: ignored. A new job requires startIn in IDLE.

Decomposition:
- Shared package cnn_accel_pkg holds:
  - ADDR_WIDTH and DIM_WIDTH defaults
  - state encoding (IDLE, CHECK, RUN, DONE)
  - a conv config struct: four dims plus two bases
- Sub-module conv_nested_counter: four cascaded wrap counters with advance enable; outputs carries and last flags. The address pointer logic stays in the top.

Test Plan:
- Data 3x3, filter 2x2, dataBase=0, filtBase=100, readyIn=1:
  - exactly 16 beats, the first 2 cycles after start
  - dataAddr = 0,1,3,4 | 1,2,4,5 | 3,4,6,7 | 4,5,7,8
  - filtAddr = 100..103 repeated
  - lastOut on beats 4, 8, 12, 16
  - doneOut the cycle after beat 16
- Same job with readyIn low for 3 cycles while beat 2 is presented: beat 2 (dataAddr=1, filtAddr=101) held unchanged for 4 cycles; sequence otherwise identical; doneOut delayed 3 cycles.
- Filter 4x2 on data 3x3: errOut one pulse 1 cycle after start; no validOut; busyOut high exactly 1 cycle.
- 1x1 filter on 1x1 data, dataBase=4095, filtBase=7: one beat, dataAddr=4095, filtAddr=7, lastOut=1; then doneOut.
- startIn re-pulsed mid-job with different dims: beat sequence unchanged from the first job.
- Assert rstIn at beat 5 of the 3x3/2x2 job: all outputs 0 immediately; no doneOut; a subsequent start runs a fresh full 16-beat job.

Source files
------------

// File: rtl/cnn_accel_pkg.sv
// Shared types for the CNN accelerator: default widths, the sequencer state
// encoding, the convolution job configuration and its validity check.
package cnn_accel_pkg;

    localparam int CNN_ADDR_WIDTH = 12;
    localparam int CNN_DIM_WIDTH  = 7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_e;

    typedef struct packed {
        logic [CNN_DIM_WIDTH-1:0]  filt_rows;
        logic [CNN_DIM_WIDTH-1:0]  filt_cols;
        logic [CNN_DIM_WIDTH-1:0]  data_rows;
        logic [CNN_DIM_WIDTH-1:0]  data_cols;
        logic [CNN_ADDR_WIDTH-1:0] data_base;
        logic [CNN_ADDR_WIDTH-1:0] filt_base;
    } conv_cfg_t;

    // A job is runnable when no dimension is zero and the filter fits inside the data.
    function automatic logic cfg_is_valid(input conv_cfg_t cfg);
        logic nonzero;
        logic fits;
        nonzero = (cfg.filt_rows != CNN_DIM_WIDTH'(0)) && (cfg.filt_cols != CNN_DIM_WIDTH'(0)) &&
                  (cfg.data_rows != CNN_DIM_WIDTH'(0)) && (cfg.data_cols != CNN_DIM_WIDTH'(0));
        fits    = (cfg.filt_rows <= cfg.data_rows) && (cfg.filt_cols <= cfg.data_cols);
        return nonzero && fits;
    endfunction

endpackage

// File: rtl/conv_nested_counter.sv
// Four cascaded wrap counters (outRow > outCol > fRow > fCol) stepped once per
// accepted beat; exposes the wrap carries and whether the next tap closes a pixel.
module conv_nested_counter
    import cnn_accel_pkg::*;
#(
    parameter int DIM_WIDTH = CNN_DIM_WIDTH
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clear_i,
    input  logic                 advance_i,
    input  logic [DIM_WIDTH-1:0] out_rows_i,
    input  logic [DIM_WIDTH-1:0] out_cols_i,
    input  logic [DIM_WIDTH-1:0] filt_rows_i,
    input  logic [DIM_WIDTH-1:0] filt_cols_i,
    output logic                 f_col_carry_o,
    output logic                 f_row_carry_o,
    output logic                 o_col_carry_o,
    output logic                 o_row_carry_o,
    output logic                 tap_last_next_o
);

    localparam logic [DIM_WIDTH-1:0] ONE  = DIM_WIDTH'(1);
    localparam logic [DIM_WIDTH-1:0] ZERO = DIM_WIDTH'(0);

    logic [DIM_WIDTH-1:0] f_col_q, f_col_d, f_row_q, f_row_d;
    logic [DIM_WIDTH-1:0] o_col_q, o_col_d, o_row_q, o_row_d;
    logic [DIM_WIDTH-1:0] f_col_adv_s, f_row_adv_s;
    logic                 f_col_last_s, f_row_last_s, o_col_last_s, o_row_last_s;

    // Carry chain and next counter values.
    always_comb begin
        f_col_last_s = (f_col_q == filt_cols_i - ONE);
        f_row_last_s = (f_row_q == filt_rows_i - ONE);
        o_col_last_s = (o_col_q == out_cols_i - ONE);
        o_row_last_s = (o_row_q == out_rows_i - ONE);

        f_col_carry_o = advance_i && f_col_last_s;
        f_row_carry_o = f_col_carry_o && f_row_last_s;
        o_col_carry_o = f_row_carry_o && o_col_last_s;
        o_row_carry_o = o_col_carry_o && o_row_last_s;

        // Tap position assuming an advance; lets the top register lastOut a beat ahead.
        f_col_adv_s = f_col_last_s ? ZERO : f_col_q + ONE;
        f_row_adv_s = f_col_last_s ? (f_row_last_s ? ZERO : f_row_q + ONE) : f_row_q;
        tap_last_next_o = (f_col_adv_s == filt_cols_i - ONE) && (f_row_adv_s == filt_rows_i - ONE);

        f_col_d = f_col_q;
        f_row_d = f_row_q;
        o_col_d = o_col_q;
        o_row_d = o_row_q;
        if (clear_i) begin
            f_col_d = ZERO;
            f_row_d = ZERO;
            o_col_d = ZERO;
            o_row_d = ZERO;
        end else if (advance_i) begin
            f_col_d = f_col_adv_s;
            f_row_d = f_row_adv_s;
            if (f_row_carry_o) begin
                o_col_d = o_col_last_s ? ZERO : o_col_q + ONE;
            end else begin
                o_col_d = o_col_q;
            end
            if (o_col_carry_o) begin
                o_row_d = o_row_last_s ? ZERO : o_row_q + ONE;
            end else begin
                o_row_d = o_row_q;
            end
        end else begin
            f_col_d = f_col_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            f_col_q <= ZERO;
            f_row_q <= ZERO;
            o_col_q <= ZERO;
            o_row_q <= ZERO;
        end else begin
            f_col_q <= f_col_d;
            f_row_q <= f_row_d;
            o_col_q <= o_col_d;
            o_row_q <= o_row_d;
        end
    end

endmodule

// File: rtl/conv_window_sequencer.sv
// Walks every output pixel and filter tap of a valid-mode 2-D convolution,
// issuing paired data/filter RAM addresses to the MAC with a ready/valid handshake.
module conv_window_sequencer
    import cnn_accel_pkg::*;
#(
    parameter int ADDR_WIDTH = CNN_ADDR_WIDTH,
    parameter int DIM_WIDTH  = CNN_DIM_WIDTH
) (
    input  logic                  clkIn,
    input  logic                  rstIn,
    input  logic                  startIn,
    input  logic [DIM_WIDTH-1:0]  filtRowsIn,
    input  logic [DIM_WIDTH-1:0]  filtColsIn,
    input  logic [DIM_WIDTH-1:0]  dataRowsIn,
    input  logic [DIM_WIDTH-1:0]  dataColsIn,
    input  logic [ADDR_WIDTH-1:0] dataBaseIn,
    input  logic [ADDR_WIDTH-1:0] filtBaseIn,
    output logic                  busyOut,
    output logic                  doneOut,
    output logic                  errOut,
    output logic [ADDR_WIDTH-1:0] dataAddrOut,
    output logic [ADDR_WIDTH-1:0] filtAddrOut,
    output logic                  validOut,
    output logic                  lastOut,
    input  logic                  readyIn
);

    seq_state_e            state_q, state_d;
    conv_cfg_t             cfg_q, cfg_d, cfg_in_s;
    logic [ADDR_WIDTH-1:0] win_row_q, win_row_d, win_q, win_d, row_q, row_d;
    logic [ADDR_WIDTH-1:0] data_addr_q, data_addr_d, filt_addr_q, filt_addr_d;
    logic                  valid_q, valid_d, last_q, last_d;
    logic                  busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic                  beat_s, cnt_clear_s;
    logic [DIM_WIDTH-1:0]  out_rows_s, out_cols_s;
    logic [ADDR_WIDTH-1:0] data_cols_s;
    logic                  f_col_carry_s, f_row_carry_s, o_col_carry_s, o_row_carry_s;
    logic                  tap_last_next_s;

    assign beat_s      = valid_q && readyIn;
    assign out_rows_s  = cfg_q.data_rows - cfg_q.filt_rows + DIM_WIDTH'(1);
    assign out_cols_s  = cfg_q.data_cols - cfg_q.filt_cols + DIM_WIDTH'(1);
    assign data_cols_s = ADDR_WIDTH'(cfg_q.data_cols);

    conv_nested_counter #(.DIM_WIDTH(DIM_WIDTH)) u_counter (
        .clk_i           (clkIn),
        .rst_i           (rstIn),
        .clear_i         (cnt_clear_s),
        .advance_i       (beat_s),
        .out_rows_i      (out_rows_s),
        .out_cols_i      (out_cols_s),
        .filt_rows_i     (cfg_q.filt_rows),
        .filt_cols_i     (cfg_q.filt_cols),
        .f_col_carry_o   (f_col_carry_s),
        .f_row_carry_o   (f_row_carry_s),
        .o_col_carry_o   (o_col_carry_s),
        .o_row_carry_o   (o_row_carry_s),
        .tap_last_next_o (tap_last_next_s)
    );

    // Sequencer next state, address pointers and registered output values.
    always_comb begin
        cfg_in_s.filt_rows = filtRowsIn;
        cfg_in_s.filt_cols = filtColsIn;
        cfg_in_s.data_rows = dataRowsIn;
        cfg_in_s.data_cols = dataColsIn;
        cfg_in_s.data_base = dataBaseIn;
        cfg_in_s.filt_base = filtBaseIn;

        state_d     = state_q;
        cfg_d       = cfg_q;
        win_row_d   = win_row_q;
        win_d       = win_q;
        row_d       = row_q;
        data_addr_d = data_addr_q;
        filt_addr_d = filt_addr_q;
        valid_d     = valid_q;
        last_d      = last_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        cnt_clear_s = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (startIn) begin
                    cfg_d   = cfg_in_s;
                    err_d   = !cfg_is_valid(cfg_in_s);
                    state_d = ST_CHECK;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CHECK: begin
                // err_q already holds the verdict on the latched config and is the errOut pulse.
                if (err_q) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d     = ST_RUN;
                    cnt_clear_s = 1'b1;
                    win_row_d   = cfg_q.data_base;
                    win_d       = cfg_q.data_base;
                    row_d       = cfg_q.data_base;
                    data_addr_d = cfg_q.data_base;
                    filt_addr_d = cfg_q.filt_base;
                    valid_d     = 1'b1;
                    last_d      = (cfg_q.filt_rows == DIM_WIDTH'(1)) && (cfg_q.filt_cols == DIM_WIDTH'(1));
                end
            end
            ST_RUN: begin
                if (beat_s) begin
                    last_d      = tap_last_next_s;
                    filt_addr_d = f_row_carry_s ? cfg_q.filt_base : filt_addr_q + ADDR_WIDTH'(1);
                    if (o_row_carry_s) begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else if (o_col_carry_s) begin
                        win_row_d   = win_row_q + data_cols_s;
                        win_d       = win_row_q + data_cols_s;
                        row_d       = win_row_q + data_cols_s;
                        data_addr_d = win_row_q + data_cols_s;
                    end else if (f_row_carry_s) begin
                        win_d       = win_q + ADDR_WIDTH'(1);
                        row_d       = win_q + ADDR_WIDTH'(1);
                        data_addr_d = win_q + ADDR_WIDTH'(1);
                    end else if (f_col_carry_s) begin
                        row_d       = row_q + data_cols_s;
                        data_addr_d = row_q + data_cols_s;
                    end else begin
                        data_addr_d = data_addr_q + ADDR_WIDTH'(1);
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
                last_d  = 1'b0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State, configuration and output registers.
    always_ff @(posedge clkIn or posedge rstIn) begin
        if (rstIn) begin
            state_q     <= ST_IDLE;
            cfg_q       <= '0;
            win_row_q   <= ADDR_WIDTH'(0);
            win_q       <= ADDR_WIDTH'(0);
            row_q       <= ADDR_WIDTH'(0);
            data_addr_q <= ADDR_WIDTH'(0);
            filt_addr_q <= ADDR_WIDTH'(0);
            valid_q     <= 1'b0;
            last_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cfg_q       <= cfg_d;
            win_row_q   <= win_row_d;
            win_q       <= win_d;
            row_q       <= row_d;
            data_addr_q <= data_addr_d;
            filt_addr_q <= filt_addr_d;
            valid_q     <= valid_d;
            last_q      <= last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign busyOut     = busy_q;
    assign doneOut     = done_q;
    assign errOut      = err_q;
    assign dataAddrOut = data_addr_q;
    assign filtAddrOut = filt_addr_q;
    assign validOut    = valid_q;
    assign lastOut     = last_q;

endmodule
